// File: rtl/axi_rd_arbiter_2m_pkg.sv
// Shared definitions for the two-master AXI read arbiter: FSM encoding and
// the fixed burst attributes of the instruction-SRAM refill.
package axi_rd_arbiter_2m_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_e;

   localparam logic [2:0] AR_SIZE_8B    = 3'd3;
   localparam logic [1:0] AR_BURST_INCR = 2'b01;

   // Refills are whole 16-byte lines, so the low address bits are dropped.
   localparam int LINE_OFF_W = 4;

endpackage

// File: rtl/axi_rd_arbiter_2m_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins outright, and a tie is
// settled by the priority pointer.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       prio,
   output logic       gnt
);

   always_comb begin
      // NOTE: give every always_comb output a value before the case so that no
      // path leaves it unassigned, which would otherwise infer a latch.
      gnt = 1'b0;
      case (req)
         2'b10:   gnt = 1'b1;
         2'b11:   gnt = prio;
         default: gnt = 1'b0;
      endcase
   end

endmodule

// File: rtl/axi_rd_arbiter_2m.sv
// Shares one AXI read-only slave between the I-cache (m0) and the D-cache (m1).
// Round-robin, one outstanding burst, grant held until the last beat.
module axi_rd_arbiter_2m
   import axi_rd_arbiter_2m_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   parameter int BEATS  = 2
) (
   input  logic              clk,
   input  logic              rst,

   input  logic [ADDR_W-1:0] m0_araddr,
   input  logic              m0_arvalid,
   output logic              m0_arready,
   output logic [DATA_W-1:0] m0_rdata,
   output logic [1:0]        m0_rresp,
   output logic              m0_rvalid,
   output logic              m0_rlast,
   input  logic              m0_rready,

   input  logic [ADDR_W-1:0] m1_araddr,
   input  logic              m1_arvalid,
   output logic              m1_arready,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [1:0]        m1_rresp,
   output logic              m1_rvalid,
   output logic              m1_rlast,
   input  logic              m1_rready,

   output logic [ADDR_W-1:0] s_araddr,
   output logic              s_arvalid,
   input  logic              s_arready,
   output logic [7:0]        s_arlen,
   output logic [2:0]        s_arsize,
   output logic [1:0]        s_arburst,
   input  logic [DATA_W-1:0] s_rdata,
   input  logic [1:0]        s_rresp,
   input  logic              s_rvalid,
   input  logic              s_rlast,
   output logic              s_rready,

   output logic              gnt,
   output logic              busy,
   output logic              err_len
);

   localparam logic [7:0]        LAST_IDX  = 8'(BEATS - 1);
   localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << LINE_OFF_W) - 1);

   state_e            state, state_nxt;
   logic              gnt_nxt, prio, prio_nxt, pick;
   logic [7:0]        cnt, cnt_nxt;
   logic              err_len_nxt;
   logic              in_data, r_hs;
   logic [ADDR_W-1:0] sel_addr;

   rr_arb2 u_rr_arb2 (
      .req  ({m1_arvalid, m0_arvalid}),
      .prio (prio),
      .gnt  (pick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples the pre-edge values regardless of statement order.
         state   <= IDLE;
         gnt     <= 1'b0;
         prio    <= 1'b0;
         cnt     <= '0;
         err_len <= 1'b0;
      end else begin
         state   <= state_nxt;
         gnt     <= gnt_nxt;
         prio    <= prio_nxt;
         cnt     <= cnt_nxt;
         err_len <= err_len_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      gnt_nxt     = gnt;
      prio_nxt    = prio;
      cnt_nxt     = cnt;
      err_len_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (m0_arvalid || m1_arvalid) begin
               gnt_nxt   = pick;
               state_nxt = ADDR;
            end
         end
         ADDR: begin
            if (s_arready) begin
               cnt_nxt   = '0;
               state_nxt = DATA;
            end
         end
         DATA: begin
            if (r_hs) begin
               cnt_nxt = cnt + 8'd1;
               // Flag both a short burst (rlast early) and a long one (no rlast
               // on the expected final beat); a long burst flags again at rlast.
               if (s_rlast) begin
                  state_nxt   = IDLE;
                  prio_nxt    = ~gnt;
                  err_len_nxt = (cnt != LAST_IDX);
               end else begin
                  err_len_nxt = (cnt == LAST_IDX);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy      = (state != IDLE);
   assign in_data   = (state == DATA);
   assign sel_addr  = gnt ? m1_araddr : m0_araddr;

   assign s_arvalid = (state == ADDR);
   assign s_araddr  = s_arvalid ? (sel_addr & LINE_MASK) : '0;
   assign s_arlen   = LAST_IDX;
   assign s_arsize  = AR_SIZE_8B;
   assign s_arburst = AR_BURST_INCR;

   assign m0_arready = s_arvalid & ~gnt & s_arready;
   assign m1_arready = s_arvalid &  gnt & s_arready;

   assign s_rready  = in_data & (gnt ? m1_rready : m0_rready);
   assign r_hs      = s_rvalid & s_rready;

   // Data and response are broadcast; only valid and last are steered.
   assign m0_rdata  = s_rdata;
   assign m1_rdata  = s_rdata;
   assign m0_rresp  = s_rresp;
   assign m1_rresp  = s_rresp;
   assign m0_rvalid = in_data & ~gnt & s_rvalid;
   assign m1_rvalid = in_data &  gnt & s_rvalid;
   assign m0_rlast  = in_data & ~gnt & s_rlast;
   assign m1_rlast  = in_data &  gnt & s_rlast;

endmodule

// File: tb/tb_axi_rd_arbiter_2m.sv
// Directed bench for axi_rd_arbiter_2m: inputs change on the falling edge and
// outputs are checked 1 ns later, away from the active rising edge.
module tb_axi_rd_arbiter_2m;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 64;
   localparam int BEATS  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [ADDR_W-1:0] m0_araddr, m1_araddr, s_araddr;
   logic              m0_arvalid, m0_arready, m1_arvalid, m1_arready;
   logic [DATA_W-1:0] m0_rdata, m1_rdata, s_rdata;
   logic [1:0]        m0_rresp, m1_rresp, s_rresp;
   logic              m0_rvalid, m0_rlast, m0_rready;
   logic              m1_rvalid, m1_rlast, m1_rready;
   logic              s_arvalid, s_arready;
   logic [7:0]        s_arlen;
   logic [2:0]        s_arsize;
   logic [1:0]        s_arburst;
   logic              s_rvalid, s_rlast, s_rready;
   logic              gnt, busy, err_len;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   axi_rd_arbiter_2m #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
      .clk        (clk),
      .rst        (rst),
      .m0_araddr  (m0_araddr),
      .m0_arvalid (m0_arvalid),
      .m0_arready (m0_arready),
      .m0_rdata   (m0_rdata),
      .m0_rresp   (m0_rresp),
      .m0_rvalid  (m0_rvalid),
      .m0_rlast   (m0_rlast),
      .m0_rready  (m0_rready),
      .m1_araddr  (m1_araddr),
      .m1_arvalid (m1_arvalid),
      .m1_arready (m1_arready),
      .m1_rdata   (m1_rdata),
      .m1_rresp   (m1_rresp),
      .m1_rvalid  (m1_rvalid),
      .m1_rlast   (m1_rlast),
      .m1_rready  (m1_rready),
      .s_araddr   (s_araddr),
      .s_arvalid  (s_arvalid),
      .s_arready  (s_arready),
      .s_arlen    (s_arlen),
      .s_arsize   (s_arsize),
      .s_arburst  (s_arburst),
      .s_rdata    (s_rdata),
      .s_rresp    (s_rresp),
      .s_rvalid   (s_rvalid),
      .s_rlast    (s_rlast),
      .s_rready   (s_rready),
      .gnt        (gnt),
      .busy       (busy),
      .err_len    (err_len)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_req(input bit m, input bit v, input logic [31:0] a);
      if (m) begin m1_arvalid = v; m1_araddr = a; end
      else   begin m0_arvalid = v; m0_araddr = a; end
   endtask

   task automatic set_rready(input bit m, input bit v);
      if (m) m1_rready = v;
      else   m0_rready = v;
   endtask

   // Entered on the falling edge where the DUT has just moved into ADDR.
   task automatic addr_phase(input bit m, input logic [31:0] exp_addr, input int stall);
      s_arready = 1'b0;
      for (int i = 0; i < stall; i++) begin
         #1;
         check("ar_stall_valid", s_arvalid, 1);
         check("ar_stall_addr", s_araddr, exp_addr);
         check("ar_stall_m0_ready", m0_arready, 0);
         check("ar_stall_m1_ready", m1_arready, 0);
         tick();
      end
      s_arready = 1'b1;
      #1;
      check("ar_valid", s_arvalid, 1);
      check("ar_addr", s_araddr, exp_addr);
      check("ar_gnt", gnt, m);
      check("ar_busy", busy, 1);
      check("ar_ready_owner", m ? m1_arready : m0_arready, 1);
      check("ar_ready_other", m ? m0_arready : m1_arready, 0);
      check("ar_attr", {s_arlen, s_arsize, s_arburst}, {8'd1, 3'd3, 2'b01});
      tick();
      s_arready = 1'b0;
      set_req(m, 1'b0, 32'h0);
   endtask

   task automatic beat(input bit m, input logic [63:0] d, input logic [1:0] resp,
                       input bit last, input int stall);
      s_rvalid = 1'b1;
      s_rdata  = d;
      s_rresp  = resp;
      s_rlast  = last;
      for (int i = 0; i < stall; i++) begin
         set_rready(m, 1'b0);
         #1;
         check("r_stall_s_rready", s_rready, 0);
         check("r_stall_valid", m ? m1_rvalid : m0_rvalid, 1);
         check("r_stall_data", m ? m1_rdata : m0_rdata, d);
         tick();
      end
      set_rready(m, 1'b1);
      #1;
      check("r_valid", m ? m1_rvalid : m0_rvalid, 1);
      check("r_data", m ? m1_rdata : m0_rdata, d);
      check("r_resp", m ? m1_rresp : m0_rresp, resp);
      check("r_last", m ? m1_rlast : m0_rlast, last);
      check("r_other_valid", m ? m0_rvalid : m1_rvalid, 0);
      check("r_other_last", m ? m0_rlast : m1_rlast, 0);
      check("r_s_rready", s_rready, 1);
      tick();
      s_rvalid = 1'b0;
      s_rlast  = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      m0_araddr = '0; m0_arvalid = 1'b0; m0_rready = 1'b1;
      m1_araddr = '0; m1_arvalid = 1'b0; m1_rready = 1'b1;
      s_arready = 1'b0; s_rdata = '0; s_rresp = '0; s_rvalid = 1'b0; s_rlast = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_gnt", gnt, 0);
      check("rst_err_len", err_len, 0);
      check("rst_valids", {s_arvalid, m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_rready}, 0);
      check("rst_araddr", s_araddr, 0);

      // Single m0 request: one-cycle latency to s_arvalid, aligned address.
      set_req(0, 1, 32'h8000_0014);
      #1;
      check("idle_no_s_arvalid", s_arvalid, 0);
      check("idle_no_m0_arready", m0_arready, 0);
      tick();
      addr_phase(0, 32'h8000_0010, 0);
      beat(0, 64'h1111, 2'b00, 0, 0);
      beat(0, 64'h2222, 2'b00, 1, 0);
      check("t1_done_busy", busy, 0);
      check("t1_err_len", err_len, 0);

      // prio is now 1, so a tie goes to m1; m0 follows after one idle cycle.
      set_req(0, 1, 32'h0000_1004);
      set_req(1, 1, 32'h0000_2008);
      tick();
      addr_phase(1, 32'h0000_2000, 0);
      beat(1, 64'hA0A0, 2'b00, 0, 0);
      beat(1, 64'hB0B0, 2'b10, 1, 0);
      check("b2b_gap_busy", busy, 0);
      check("b2b_gap_arvalid", s_arvalid, 0);
      tick();
      addr_phase(0, 32'h0000_1000, 0);
      beat(0, 64'hC0C0, 2'b00, 0, 0);
      beat(0, 64'hD0D0, 2'b00, 1, 0);

      // After a reset a tie goes to m0; m1 then sees an arready stall and
      // holds rready low for three cycles on its first beat.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_req(0, 1, 32'h1000_0008);
      set_req(1, 1, 32'h2000_003C);
      tick();
      addr_phase(0, 32'h1000_0000, 0);
      beat(0, 64'h0101, 2'b00, 0, 0);
      beat(0, 64'h0202, 2'b00, 1, 0);
      check("tie_gap_busy", busy, 0);
      tick();
      addr_phase(1, 32'h2000_0030, 4);
      beat(1, 64'h0303, 2'b00, 0, 3);
      beat(1, 64'h0404, 2'b00, 1, 0);
      check("stall_done_busy", busy, 0);
      check("stall_done_err_len", err_len, 0);
      set_req(0, 1, 32'h3000_0000);
      set_req(1, 1, 32'h4000_0000);
      tick();
      addr_phase(0, 32'h3000_0000, 0);
      beat(0, 64'h0505, 2'b00, 0, 0);
      beat(0, 64'h0606, 2'b00, 1, 0);
      tick();
      addr_phase(1, 32'h4000_0000, 0);
      beat(1, 64'h0707, 2'b00, 0, 0);
      beat(1, 64'h0808, 2'b00, 1, 0);

      // Three-beat burst from the slave: flagged at beat 2 and again at rlast.
      set_req(1, 1, 32'h5000_0000);
      tick();
      addr_phase(1, 32'h5000_0000, 0);
      beat(1, 64'h0909, 2'b00, 0, 0);
      check("long_b1_err_len", err_len, 0);
      beat(1, 64'h0A0A, 2'b00, 0, 0);
      check("long_b2_err_len", err_len, 1);
      check("long_b2_busy", busy, 1);
      tick();
      check("long_gap_err_len", err_len, 0);
      beat(1, 64'h0B0B, 2'b00, 1, 0);
      check("long_b3_err_len", err_len, 1);
      check("long_b3_busy", busy, 0);
      tick();
      check("long_after_err_len", err_len, 0);

      // Short burst: rlast on the first beat.
      set_req(0, 1, 32'h6000_0000);
      tick();
      addr_phase(0, 32'h6000_0000, 0);
      beat(0, 64'h0C0C, 2'b00, 1, 0);
      check("short_busy", busy, 0);
      check("short_err_len", err_len, 1);
      tick();
      check("short_after_err_len", err_len, 0);

      // prio is 1 here; reset in DATA must clear it so the next tie goes to m0.
      set_req(0, 1, 32'h7000_0000);
      tick();
      addr_phase(0, 32'h7000_0000, 0);
      beat(0, 64'h0D0D, 2'b00, 0, 0);
      s_rvalid = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      s_rvalid = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_gnt", gnt, 0);
      check("midrst_err_len", err_len, 0);
      check("midrst_valids", {s_arvalid, m0_rvalid, m1_rvalid, s_rready}, 0);
      set_req(0, 1, 32'h7100_0004);
      set_req(1, 1, 32'h7200_0018);
      tick();
      addr_phase(0, 32'h7100_0000, 0);
      beat(0, 64'h0E0E, 2'b00, 0, 0);
      beat(0, 64'h0F0F, 2'b00, 1, 0);
      tick();
      addr_phase(1, 32'h7200_0010, 0);
      beat(1, 64'h1010, 2'b01, 0, 0);
      beat(1, 64'h2020, 2'b00, 1, 0);
      check("final_busy", busy, 0);
      check("final_err_len", err_len, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/axi_rd_arbiter_2m.md
Name: axi_rd_arbiter_2m

Overview:
- Shares one AXI read-only slave (instruction SRAM, 16-byte refill as INCR burst of 2×64-bit beats) between two cache masters: m0 = I-cache, m1 = D-cache.
- Round-robin arbitration, one outstanding transaction, grant held until the last beat.
- Sits between the cache refill FSMs and the SRAM AXI read port.
- Drives fixed burst attributes and flags beat-count mismatches.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 64, beat width.
- BEATS, 2, beats per burst; drives arlen = BEATS-1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- m0_araddr  in  ADDR_W  I-cache read address.
- m0_arvalid  in  1  I-cache address valid.
- m0_arready  out  1  I-cache address accepted.
- m0_rdata  out  DATA_W  beat data to I-cache.
- m0_rresp  out  2  beat response to I-cache.
- m0_rvalid  out  1  beat valid to I-cache.
- m0_rlast  out  1  last beat to I-cache.
- m0_rready  in  1  I-cache beat ready.
- m1_* : same set and directions as m0_*, for the D-cache.
- s_araddr  out  ADDR_W  address to slave; {m_araddr[ADDR_W-1:4], 4'b0}.
- s_arvalid  out  1  address valid to slave.
- s_arready  in  1  slave accepts address.
- s_arlen  out  8  BEATS-1.
- s_arsize  out  3  3'd3 (8 bytes).
- s_arburst  out  2  2'b01 (INCR).
- s_rdata  in  DATA_W  beat data from slave.
- s_rresp  in  2  beat response from slave.
- s_rvalid  in  1  beat valid from slave.
- s_rlast  in  1  last beat from slave.
- s_rready  out  1  beat ready to slave.
- gnt  out  1  current owner (0 = m0, 1 = m1).
- busy  out  1  FSM not in IDLE.
- err_len  out  1  one-cycle pulse on beat-count mismatch.

Behaviour:
- FSM states IDLE, ADDR, DATA; registers: state, gnt, prio (priority pointer), beat counter cnt.
- Reset (rst=1 at clk edge): state=IDLE, gnt=0, prio=0, cnt=0, err_len=0. All valid/ready outputs 0; s_araddr=0.
- IDLE:
  - If any m*_arvalid: choose the requester. Both requesting → the one indicated by prio.
  - Register gnt, go to ADDR.
  - No master arready or slave arvalid is asserted in IDLE. Request-to-s_arvalid latency is 1 cycle.
- ADDR:
  - s_arvalid=1; s_araddr from the granted master, 16-byte aligned.
  - m[gnt]_arready = s_arready (combinational pass-through); the other master's arready=0.
  - On s_arvalid&&s_arready: cnt=0, go to DATA.
  - The requester must hold arvalid/araddr stable until arready (AXI rule). The arbiter does not re-arbitrate in ADDR.
- DATA:
  - m[gnt]_rvalid = s_rvalid; s_rready = m[gnt]_rready.
  - rdata, rresp and rlast are forwarded to the granted master; the other master sees rvalid=0 and rlast=0. rdata may be broadcast.
  - Each handshake (s_rvalid&&s_rready) increments cnt.
  - Handshake with s_rlast=1: go to IDLE and set prio = ~gnt. err_len pulses the next cycle if cnt != BEATS-1 at that beat.
  - If cnt reaches BEATS-1 on a handshake with s_rlast=0: err_len pulses; stay in DATA until rlast.
  - Slave stall (s_rvalid=0) or master stall (rready=0): wait indefinitely, no timeout.
- Back-to-back: one IDLE cycle between transactions is required.
- Master deasserting arvalid in IDLE before grant: no transaction.
- busy = (state != IDLE).
- Reset mid-transaction: immediate return to IDLE, outputs to reset values. Slave is reset by the same rst.

Decomposition:
- Shared package: state encoding (IDLE/ADDR/DATA), burst constants (arsize 3'd3, arburst INCR 2'b01, 16-byte line alignment mask).
- Sub-module rr_arb2: 2-way round-robin picker; inputs req[1:0], prio; output gnt.
- Mux and FSM live in the top module.

Test Plan:
- Single m0 request, araddr=0x80000014, slave arready immediate, 2 beats 0x1111/0x2222 → s_araddr=0x80000010; s_arvalid 1 cycle after request; m0 gets both beats, rlast on the 2nd; m1_rvalid stays 0; prio=1 after.
- m0 and m1 request the same cycle after reset → m0 served first (gnt=0), then m1 (araddr passed through aligned); the following tie goes to m0 again.
- m1 holds rready=0 for 3 cycles during beat 1 → s_rready=0 for those cycles; data held; completion after rready rises; no beat lost or duplicated.
- Slave asserts rlast on beat 1 (short burst) → return to IDLE, err_len=1 for one cycle; a 3-beat burst also gives err_len=1 when beat 2 has rlast=0.
- rst=1 asserted in DATA after beat 1 → next cycle state=IDLE, busy=0, all valids 0, gnt=0, prio=0; a new m1 request is then served normally.
- Slave holds arready=0 for 4 cycles → s_arvalid and s_araddr stable; m*_arready=0 until the accept cycle.
